// File: rtl/mio_responder.sv
// mio_responder: CPU memory/IO bus responder with internal RAM, GPIO and a free-running counter.
// Optional wait states between acceptance and completion are enabled by defining MIO_WAIT_EN.
module mio_responder #(
    parameter int unsigned RAM_AW      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        cpu_mio,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [31:0] cnt_out,
    output logic        err
);

`ifdef MIO_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int unsigned WAIT_N     = WAIT_EN ? WAIT_CYCLES : 0;
    localparam int unsigned WCNT_W     = 4;
    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam logic [29:0] GPIO_WADDR = 30'h3800_0000;
    localparam logic [29:0] CNT_WADDR  = 30'h3C00_0000;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_GPIO, REG_CNT, REG_NONE} region_t;

    state_t              state;
    region_t             region_q;
    logic                bad_q;
    logic                rd_q;
    logic [RAM_AW-1:0]   idx_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [31:0]         ram [RAM_DEPTH];

    region_t             region_c;
    region_t             sel_region_c;
    logic                accept_c;
    logic                bad_c;
    logic                wr_c;
    logic                enter_resp_c;
    logic                sel_bad_c;
    logic                sel_rd_c;
    logic [RAM_AW-1:0]   sel_idx_c;
    logic [31:0]         rd_val_c;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    // Decode the live request; reads are sourced from the live request when going
    // straight from IDLE to RESP, otherwise from the fields latched at acceptance.
    always_comb begin
        region_c = REG_NONE;
        if (addr[31:28] == 4'h0)          region_c = REG_RAM;
        else if (addr[31:2] == GPIO_WADDR) region_c = REG_GPIO;
        else if (addr[31:2] == CNT_WADDR)  region_c = REG_CNT;

        accept_c = (state == IDLE) && cpu_mio && (mem_r || mem_w);
        bad_c    = mem_r && mem_w;
        wr_c     = accept_c && mem_w && !mem_r;

        if (state == IDLE) begin
            sel_region_c = region_c;
            sel_bad_c    = bad_c;
            sel_rd_c     = mem_r && !mem_w;
            sel_idx_c    = addr[RAM_AW+1:2];
        end else begin
            sel_region_c = region_q;
            sel_bad_c    = bad_q;
            sel_rd_c     = rd_q;
            sel_idx_c    = idx_q;
        end

        enter_resp_c = (accept_c && (WAIT_N == 0)) || ((state == WAIT) && (wcnt_q == '0));

        rd_val_c = '0;
        case (sel_region_c)
            REG_RAM:  rd_val_c = ram[sel_idx_c];
            REG_GPIO: rd_val_c = {16'h0000, sw_in};
            REG_CNT:  rd_val_c = cnt_out;
            default:  rd_val_c = '0;
        endcase
    end

    // RAM is deliberately outside the reset domain so its contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_c && (region_c == REG_RAM)) begin
            ram[addr[RAM_AW+1:2]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            region_q  <= REG_NONE;
            bad_q     <= 1'b0;
            rd_q      <= 1'b0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            mio_ready <= 1'b0;
            rdata     <= '0;
            led_out   <= '0;
            cnt_out   <= '0;
            err       <= 1'b0;
        end else begin
            mio_ready <= 1'b0;
            cnt_out   <= (wr_c && (region_c == REG_CNT)) ? wdata : cnt_out + 32'd1;

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        region_q <= region_c;
                        bad_q    <= bad_c;
                        rd_q     <= mem_r && !mem_w;
                        idx_q    <= addr[RAM_AW+1:2];
                        if (bad_c || (region_c == REG_NONE)) err <= 1'b1;
                        if (wr_c && (region_c == REG_GPIO)) led_out <= wdata[15:0];
                        if (WAIT_N == 0) begin
                            state <= RESP;
                        end else begin
                            state  <= WAIT;
                            wcnt_q <= WCNT_W'(WAIT_N - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wcnt_q == '0) state <= RESP;
                    else              wcnt_q <= wcnt_q - WCNT_W'(1);
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Completion: bad or unmapped accesses return zero, writes keep rdata.
            if (enter_resp_c) begin
                mio_ready <= 1'b1;
                if (sel_bad_c || (sel_region_c == REG_NONE)) rdata <= '0;
                else if (sel_rd_c)                           rdata <= rd_val_c;
            end
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: scoreboard of expected completions popped on mio_ready.
module tb_mio_responder;

    localparam int unsigned W_CYC = 2;
`ifdef MIO_WAIT_EN
    localparam int LAT = W_CYC + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        mem_r   = 1'b0;
    logic        mem_w   = 1'b0;
    logic        cpu_mio = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;
    logic [15:0] sw_in   = '0;
    logic [31:0] rdata;
    logic        mio_ready;
    logic [15:0] led_out;
    logic [31:0] cnt_out;
    logic        err;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic        prev_ready = 1'b0;

    mio_responder #(.RAM_AW(8), .WAIT_CYCLES(W_CYC)) dut (
        .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .cpu_mio(cpu_mio),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
        .sw_in(sw_in), .led_out(led_out), .cnt_out(cnt_out), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Completion monitor: every mio_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mio_ready) begin
            check("ready_single_pulse", 32'(prev_ready), 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_ready", 32'(mio_ready), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.tag, "_rdata"}, rdata, mon_e.rdata);
                check({mon_e.tag, "_latency"}, 32'(cyc - mon_e.acc), 32'(LAT));
            end
        end
        prev_ready = mio_ready;
    end

    task automatic push_exp(input string tag, input logic [31:0] rd);
        exp_t e;
        e.tag   = tag;
        e.rdata = rd;
        e.acc   = cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check({tag, "_timeout"}, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic xact(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input bit hold);
        @(negedge clk);
        push_exp(tag, exp_rd);
        mem_r = r; mem_w = w; addr = a; wdata = d; cpu_mio = 1'b1;
        if (!hold) begin
            @(negedge clk);
            mem_r = 1'b0; mem_w = 1'b0; addr = ~a; wdata = ~d; cpu_mio = 1'b0;
        end
        wait_drain(tag);
        mem_r = 1'b0; mem_w = 1'b0; cpu_mio = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(mio_ready), 32'h0);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_cnt", cnt_out, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // RAM write/read, byte-offset bits ignored, index boundaries
        xact("ram_wr10", 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0);
        xact("ram_rd10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b1);
        xact("ram_wr0", 1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h1234_5678, 1'b0);
        xact("ram_wrmax", 1'b0, 1'b1, 32'h0000_03FC, 32'hFFFF_0000, 32'h1234_5678, 1'b1);
        xact("ram_rdmax", 1'b1, 1'b0, 32'h0000_03FF, 32'h0, 32'hFFFF_0000, 1'b0);
        xact("ram_rd0", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0);
        xact("ram_rd13", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h1234_5678, 1'b0);

        // GPIO
        sw_in = 16'hA5A5;
        xact("gpio_rd", 1'b1, 1'b0, 32'hE000_0000, 32'h0, 32'h0000_A5A5, 1'b0);
        xact("gpio_wr", 1'b0, 1'b1, 32'hE000_0000, 32'hFFFF_00FF, 32'h0000_A5A5, 1'b0);
        check("led_out", 32'(led_out), 32'h0000_00FF);

        // Counter load and wrap
        @(negedge clk);
        push_exp("cnt_wr", 32'h0000_A5A5);
        mem_w = 1'b1; addr = 32'hF000_0000; wdata = 32'hFFFF_FFFE; cpu_mio = 1'b1;
        @(negedge clk);
        check("cnt_load", cnt_out, 32'hFFFF_FFFE);
        mem_w = 1'b0; cpu_mio = 1'b0;
        @(negedge clk);
        check("cnt_inc", cnt_out, 32'hFFFF_FFFF);
        @(negedge clk);
        check("cnt_wrap", cnt_out, 32'h0000_0000);
        wait_drain("cnt_wr");

        // Requests ignored without bus ownership
        mem_r = 1'b1; addr = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cpu_mio_gate", 32'(mio_ready), 32'h0);
        end
        mem_r = 1'b0;
        check("err_clear", 32'(err), 32'h0);

        // Unmapped and bad accesses
        xact("unmapped_rd", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        check("err_unmapped", 32'(err), 32'h1);
        xact("ram_rd10b", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);
        xact("bad_rw", 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("ram_rd10c", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);
        check("err_sticky", 32'(err), 32'h1);

        // Reset while the access is in flight: abandoned, committed write persists
        @(negedge clk);
        push_exp("rst_flight", 32'h1234_5678);
        mem_w = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_F00D; cpu_mio = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1; mem_w = 1'b0; cpu_mio = 1'b0;
        #1;
        sbq.delete();
        check("rst2_ready", 32'(mio_ready), 32'h0);
        check("rst2_rdata", rdata, 32'h0);
        check("rst2_led", 32'(led_out), 32'h0);
        check("rst2_cnt", cnt_out, 32'h0);
        check("rst2_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst2_no_ready", 32'(mio_ready), 32'h0);
        end
        xact("rst_persist", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);
        xact("ram_keep", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);
        check("err_after_rst", 32'(err), 32'h0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
